// File: rtl/pipelined_hazard_controller.sv
// Pipelined control unit: decodes ID into a 17-bit bundle, carries it through EX/MEM/WB,
// and resolves RAW/load-use hazards, branch flushes, forwarding selects and a sticky ecall halt.
module pipelined_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            Funct,
  input  logic [4:0]            OpCode,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  input  logic                  wb_halt_req,
  output logic [16:0]           ex_ctrl,
  output logic [16:0]           mem_ctrl,
  output logic [16:0]           wb_ctrl,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  halt
);

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_IMM = 5'b00100, OP_STORE = 5'b01000,
                         OP_REG = 5'b01100, OP_BRANCH = 5'b11000, OP_JALR = 5'b11001,
                         OP_JAL = 5'b11011, OP_SYSTEM = 5'b11100;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_MUL = 4'd10;

  localparam int B_MEMTOREG = 12, B_MEMWRITE = 11, B_ALUSRC = 10, B_REGWRITE = 9, B_ECALL = 8,
                 B_STYPE = 7, B_BEQ = 6, B_BNE = 5, B_JAL = 4, B_JALR = 3, B_SLTIU = 2,
                 B_SB = 1, B_BLT = 0;

  typedef struct packed {
    logic                  valid;
    logic [16:0]           ctrl;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } ex_stage_t;

  typedef struct packed {
    logic                  valid;
    logic [16:0]           ctrl;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;

  ex_stage_t ex_q, ex_d;
  stage_t    mem_q, wb_q;
  logic      halt_q;

  logic [2:0]  funct3;
  logic        funct7b5, funct7b0;
  logic [3:0]  aluByF3;
  logic [16:0] idCtrl;
  logic        loadUse, rawHazard, hazard, branchFlush, haltSet, advance;

  assign funct3   = Funct[2:0];
  assign funct7b5 = Funct[4];
  assign funct7b0 = Funct[3];

  always_comb begin
    aluByF3 = ALU_ADD;
    case (funct3)
      3'b001:  aluByF3 = ALU_SLL;
      3'b010:  aluByF3 = ALU_SLT;
      3'b011:  aluByF3 = ALU_SLTU;
      3'b100:  aluByF3 = ALU_XOR;
      3'b101:  aluByF3 = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  aluByF3 = ALU_OR;
      3'b111:  aluByF3 = ALU_AND;
      default: aluByF3 = ALU_ADD;
    endcase
  end

  // Unknown opcodes decode to an all-zero bundle so they behave like a nop downstream.
  always_comb begin
    idCtrl = '0;
    case (OpCode)
      OP_REG: begin
        idCtrl[16:13] = funct7b0 ? ALU_MUL :
                        ((funct3 == 3'b000) && funct7b5) ? ALU_SUB : aluByF3;
        idCtrl[B_REGWRITE] = 1'b1;
      end
      OP_IMM: begin
        idCtrl[16:13]      = aluByF3;
        idCtrl[B_ALUSRC]   = 1'b1;
        idCtrl[B_REGWRITE] = 1'b1;
        idCtrl[B_SLTIU]    = (funct3 == 3'b011);
      end
      OP_LOAD: begin
        idCtrl[B_MEMTOREG] = 1'b1;
        idCtrl[B_ALUSRC]   = 1'b1;
        idCtrl[B_REGWRITE] = 1'b1;
      end
      OP_STORE: begin
        idCtrl[B_MEMWRITE] = 1'b1;
        idCtrl[B_ALUSRC]   = 1'b1;
        idCtrl[B_STYPE]    = 1'b1;
        idCtrl[B_SB]       = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  begin idCtrl[16:13] = ALU_SUB; idCtrl[B_BEQ] = 1'b1; end
          3'b001:  begin idCtrl[16:13] = ALU_SUB; idCtrl[B_BNE] = 1'b1; end
          3'b100:  begin idCtrl[16:13] = ALU_SLT; idCtrl[B_BLT] = 1'b1; end
          default: idCtrl = '0;
        endcase
      end
      OP_JAL: begin
        idCtrl[B_REGWRITE] = 1'b1;
        idCtrl[B_JAL]      = 1'b1;
      end
      OP_JALR: begin
        idCtrl[B_ALUSRC]   = 1'b1;
        idCtrl[B_REGWRITE] = 1'b1;
        idCtrl[B_JALR]     = 1'b1;
      end
      OP_SYSTEM: idCtrl[B_ECALL] = 1'b1;
      default:   idCtrl = '0;
    endcase
  end

  function automatic logic tagMatch(input logic valid, input logic regWrite,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] rs);
    return valid && regWrite && (rd != '0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] rs);
    if (tagMatch(mem_q.valid, mem_q.ctrl[B_REGWRITE], mem_q.rd, rs)) return 2'b10;
    if (tagMatch(wb_q.valid, wb_q.ctrl[B_REGWRITE], wb_q.rd, rs))    return 2'b01;
    return 2'b00;
  endfunction

  // Both source tags are always compared, even when the format ignores rs2.
  always_comb begin
    loadUse = id_valid && ex_q.ctrl[B_MEMTOREG] &&
              (tagMatch(ex_q.valid, ex_q.ctrl[B_REGWRITE], ex_q.rd, id_rs1) ||
               tagMatch(ex_q.valid, ex_q.ctrl[B_REGWRITE], ex_q.rd, id_rs2));
    rawHazard = id_valid &&
              (tagMatch(ex_q.valid, ex_q.ctrl[B_REGWRITE], ex_q.rd, id_rs1) ||
               tagMatch(ex_q.valid, ex_q.ctrl[B_REGWRITE], ex_q.rd, id_rs2) ||
               tagMatch(mem_q.valid, mem_q.ctrl[B_REGWRITE], mem_q.rd, id_rs1) ||
               tagMatch(mem_q.valid, mem_q.ctrl[B_REGWRITE], mem_q.rd, id_rs2));
    hazard      = FORWARD_EN ? loadUse : rawHazard;
    branchFlush = ex_q.valid && ex_branch_taken;
    flush_if_id = !halt_q && branchFlush;
    stall_if_id = halt_q || (hazard && !branchFlush);
    fwd_a       = FORWARD_EN ? fwdSel(ex_q.rs1) : 2'b00;
    fwd_b       = FORWARD_EN ? fwdSel(ex_q.rs2) : 2'b00;
  end

  // The halting edge itself freezes the pipe, so the ecall stays visible in WB while halted.
  always_comb begin
    haltSet = !halt_q && wb_q.valid && wb_q.ctrl[B_ECALL] && wb_halt_req;
    advance = !halt_q && !haltSet;
    ex_d    = '{valid: id_valid, ctrl: idCtrl, rs1: id_rs1, rs2: id_rs2, rd: id_rd};
    if (stall_if_id || flush_if_id) ex_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      if (haltSet) halt_q <= 1'b1;
      if (advance) begin
        wb_q  <= mem_q;
        mem_q <= '{valid: ex_q.valid, ctrl: ex_q.ctrl, rd: ex_q.rd};
        ex_q  <= ex_d;
      end
    end
  end

  assign ex_ctrl   = ex_q.ctrl;
  assign mem_ctrl  = mem_q.ctrl;
  assign wb_ctrl   = wb_q.ctrl;
  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;
  assign ex_rs1    = ex_q.rs1;
  assign ex_rs2    = ex_q.rs2;
  assign ex_rd     = ex_q.rd;
  assign mem_rd    = mem_q.rd;
  assign wb_rd     = wb_q.rd;
  assign halt      = halt_q;

endmodule

// File: doc/pipelined_hazard_controller.md
Name: pipelined_hazard_controller

Overview:
- Pipelined-CPU successor to the single-cycle hard-wired controller.
- Decodes Funct/OpCode in ID into a 17-bit control bundle and carries it, with rd/rs tags, through EX, MEM and WB pipeline registers.
- Detects RAW and load-use hazards, generates stall/flush/forwarding selects, and applies a sticky halt on an exiting ecall.
- Sits between IF/ID register and datapath; datapath consumes per-stage bundles.

Parameters:
REG_ADDR_W, 5, register-address width for rs1/rs2/rd tags
FORWARD_EN, 1, 1 = forwarding mode (stall only on load-use); 0 = no forwarding (stall on every RAW against EX or MEM)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Funct  input  5  ID compressed funct: bit4 = funct7[5], bit3 = funct7[0], bits2:0 = funct3
OpCode  input  5  ID opcode[6:2]
id_valid  input  1  IF/ID holds a real instruction
id_rs1, id_rs2, id_rd  input  REG_ADDR_W each  ID register fields
ex_branch_taken  input  1  EX-resolved taken branch/jal/jalr; ignored unless ex_valid
wb_halt_req  input  1  datapath exit condition for the ecall in WB (a7 == 10)
ex_ctrl, mem_ctrl, wb_ctrl  output  17 each  stage bundles
ex_valid, mem_valid, wb_valid  output  1 each  stage holds a real instruction
ex_rs1, ex_rs2  output  REG_ADDR_W each  EX source tags
ex_rd, mem_rd, wb_rd  output  REG_ADDR_W each  destination tags
fwd_a, fwd_b  output  2 each  EX operand select: 00 regfile, 10 from MEM, 01 from WB
stall_if_id  output  1  hold PC and IF/ID
flush_if_id  output  1  clear IF/ID to bubble
halt  output  1  sticky stop

Behaviour:
- Bundle bit order, 16 down to 0: ALUOP[3:0], MemtoReg, MemWrite, ALU_Src, RegWrite, ecall, S_Type, BEQ, BNE, jal, jalr, sltiu, sb, blt.
- Decode is combinational in ID via the existing arithmetic_controller and control_signal_controller, with funct7 = {0, Funct[4], 0000, Funct[3]}.
- Reset (async, rst_n = 0): all *_valid = 0, all *_ctrl = 0, all tags = 0, halt = 0, fwd = 00, stall = flush = 0.
  - Reset mid-stall or mid-flush clears everything immediately.
- Per rising edge when not halted: WB <= MEM, MEM <= EX, EX <= ID-next.
  - ID-next is the decoded bundle with ID tags and valid = id_valid.
  - ID-next is a bubble (valid = 0, ctrl = 0, tags = 0) on stall or flush.
- Latency: a bundle appears on ex_ctrl 1 cycle after ID, mem_ctrl 2 cycles after, wb_ctrl 3 cycles after.
- Tag match rule: stage valid, stage RegWrite = 1, stage rd != 0, and stage rd == the compared rs.
  - rs1 and rs2 are always both compared, even for formats that do not use rs2.
- Load-use hazard: EX tag-matches id_rs1 or id_rs2 and EX MemtoReg = 1, with id_valid = 1.
- FORWARD_EN = 1:
  - stall_if_id = load-use hazard.
  - fwd_a: 10 if MEM tag-matches ex_rs1; else 01 if WB tag-matches ex_rs1; else 00. MEM has priority.
  - fwd_b: same rule on ex_rs2.
- FORWARD_EN = 0:
  - fwd_a = fwd_b = 00 always.
  - stall_if_id = id_valid and (EX or MEM tag-matches id_rs1 or id_rs2).
  - WB is not checked; the regfile is written first half / read second half.
- Flush: flush_if_id = ex_valid and ex_branch_taken. The next EX is a bubble.
  - Flush overrides stall in the same cycle: stall_if_id forced 0, and the stalled ID instruction is discarded.
- Halt: set on the edge where wb_valid, wb ecall and wb_halt_req are all 1. Sticky until reset.
  - While halt = 1: all stage registers hold, stall_if_id = 1, flush_if_id = 0, fwd outputs still computed from held state.
  - The WB instruction completes its writeback in the cycle halt is set.
- Outputs: stall/flush/fwd are combinational from current stage registers and ID inputs. Bundles and tags come straight from registers.

Test Plan:
- Reset: hold rst_n = 0 mid-stream, release -> all valid = 0, ctrl = 0, halt = 0.
  - Issue add (OpCode 01100, Funct 00000) -> ex_ctrl RegWrite = 1 one cycle later.
  - Same instruction reaches wb_ctrl 3 cycles after issue.
- FORWARD_EN = 1, lw x5 then add x6,x5,x1 -> one cycle stall_if_id = 1 and EX bubble.
  - Next cycle: fwd_a = 01 (from WB).
- FORWARD_EN = 1, add x5 then sub x7,x5,x5 back-to-back -> no stall, fwd_a = fwd_b = 10.
  - With rd = x0 instead: fwd = 00.
- FORWARD_EN = 0, same add/sub pair -> stall_if_id high for exactly 2 cycles, then sub enters EX with fwd = 00.
- Branch: beq in EX with ex_branch_taken = 1 while a load-use stall is present -> flush_if_id = 1, stall_if_id = 0.
  - Next EX is a bubble (ex_valid = 0).
- ecall in WB with wb_halt_req = 1 -> halt = 1 next edge; stages frozen for 10 cycles.
  - Same ecall with wb_halt_req = 0 -> no halt.
  - Then rst_n pulse -> halt = 0.
